// File: rtl/shifter_pkg.sv
// shifter_pkg: shared defaults, mode encodings and FSM states for seq_shifter
package shifter_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int AMT_W_DEF = 3;
  localparam logic [1:0] MODE_LOG = 2'b00;
  localparam logic [1:0] MODE_ARI = 2'b01;
  localparam logic [1:0] MODE_ROT = 2'b10;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/shift_step.sv
// shift_step: one-bit logical/arithmetic/rotate shift in either direction
module shift_step import shifter_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] d,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] q
);
  logic fill_l, fill_r;
  // reserved mode 11 falls through to logical fill
  assign fill_l = mode == MODE_ROT ? d[WIDTH-1] : 1'b0;
  assign fill_r = mode == MODE_ROT ? d[0] : mode == MODE_ARI ? d[WIDTH-1] : 1'b0;
  assign q = dir ? {fill_r, d[WIDTH-1:1]} : {d[WIDTH-2:0], fill_l};
endmodule

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle barrel-less shifter, one bit per clock with valid/ready handshakes
module seq_shifter import shifter_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AMT_W = AMT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_dir,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);
  state_t state, state_nxt;
  logic [WIDTH-1:0] data, step;
  logic [AMT_W-1:0] cnt;
  logic dir;
  logic [1:0] mode;
  shift_step #(.WIDTH(WIDTH)) u_step (.d(data), .dir(dir), .mode(mode), .q(step));
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  assign out_data  = data;
  always_comb begin
    state_nxt = state == IDLE  ? (in_valid ? (in_amt == '0 ? DONE : SHIFT) : IDLE) :
                state == SHIFT ? (cnt == AMT_W'(1) ? DONE : SHIFT) :
                state == DONE  ? (out_ready ? IDLE : DONE) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      data  <= '0;
      cnt   <= '0;
      dir   <= 1'b0;
      mode  <= MODE_LOG;
    end else begin
      state <= state_nxt;
      if (in_valid && in_ready) begin
        data <= in_data;
        cnt  <= in_amt;
        dir  <= in_dir;
        mode <= in_mode;
      end else if (state == SHIFT) begin
        data <= step;
        cnt  <= cnt - 1'b1;
      end
    end
  end
endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the data width in bits.
REQ-002 The block SHALL have parameter AMT_W, default 3, meaning the shift-amount width; AMT_W = clog2(WIDTH).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge triggered.
REQ-004 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: a request is present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 The block SHALL have port in_data, input, WIDTH bits: the operand.
REQ-008 The block SHALL have port in_amt, input, AMT_W bits: the shift count, 0..WIDTH-1.
REQ-009 The block SHALL have port in_dir, input, 1 bit: 0 = left, 1 = right.
REQ-010 The block SHALL have port in_mode, input, 2 bits: 00 = logical, 01 = arithmetic, 10 = rotate, 11 = reserved (treated as logical).
REQ-011 The block SHALL have port out_valid, output, 1 bit: a result is present.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 The block SHALL have port out_data, output, WIDTH bits: the shifted result.
REQ-014 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; a request is accepted on a clock edge where in_valid && in_ready.
REQ-017 On acceptance, the block SHALL capture in_data, in_dir and in_mode into internal registers and load the counter with in_amt.
REQ-018 On acceptance with in_amt == 0, the next state SHALL be DONE with the data unchanged; otherwise the next state SHALL be SHIFT.
REQ-019 In SHIFT, each clock edge SHALL apply exactly one 1-bit step to the data register and decrement the counter.
REQ-020 The transition SHALL be to DONE on the edge where the counter goes from 1 to 0.
REQ-021 Latency: out_valid SHALL rise N clock edges after the acceptance edge for N >= 1, and 1 edge after it for N = 0.
REQ-022 Logical left step: {d[W-2:0],0}; logical right step: {0,d[W-1:1]}.
REQ-023 Arithmetic right step: {d[W-1],d[W-1:1]}; arithmetic left SHALL equal logical left.
REQ-024 Rotate left step: {d[W-2:0],d[W-1]}; rotate right step: {d[0],d[W-1:1]}.
REQ-025 In DONE, out_valid SHALL be 1 and out_data SHALL hold stable until out_ready is sampled high.
REQ-026 On the edge where out_valid && out_ready, the next state SHALL be IDLE; in_ready rises in the following cycle, with no same-cycle re-acceptance.
REQ-027 out_data SHALL always reflect the data register; it is valid only while out_valid is high.
REQ-028 A change on in_* after acceptance SHALL have no effect on the operation in progress.
REQ-029 out_ready asserted outside DONE SHALL be ignored.

Reset
REQ-030 While rst_n is low at a clock edge, the state SHALL become IDLE, the data register and counter SHALL become 0, and out_valid SHALL become 0.
REQ-031 After reset, in_ready = 1 and busy = 0.
REQ-032 Reset in SHIFT or DONE SHALL abort the operation with no result delivered.
REQ-033 Reset SHALL take precedence over any handshake in the same cycle.

Structure
REQ-034 Package shifter_pkg SHALL hold the WIDTH/AMT_W defaults, the mode encodings (MODE_LOG, MODE_ARI, MODE_ROT) and the state enumeration.
REQ-035 A combinational sub-module shift_step (data, dir, mode -> 1-bit-shifted data) SHALL implement REQ-022..024; it is instantiated once.

Verification
REQ-036 Scenario: reset, then in_data=1101_0110, amt=3, dir=0, mode=00 -> out_data=1011_0000, out_valid 3 edges after acceptance.
REQ-037 Scenario: in_data=1001_0000, amt=2, dir=1, mode=01 -> 1110_0100; mode=00 -> 0010_0100.
REQ-038 Scenario: in_data=1000_0001, amt=1, dir=0, mode=10 -> 0000_0011; amt=7, dir=1, mode=10 -> 0000_0011.
REQ-039 Scenario: amt=0 with any data -> out_data equals in_data, out_valid 1 edge after acceptance.
REQ-040 Scenario: out_ready held low for 5 cycles in DONE -> out_data stable and in_ready=0 throughout; in_valid pulses during this time are ignored.
REQ-041 Scenario: rst_n low mid-SHIFT (amt=5, after 2 steps) -> next cycle state IDLE, out_valid=0, out_data=0, and no result ever appears.
